dmem_arbiter: RTL and testbench

Single-port data-memory arbiter placed between the pipeline's EX/MEM stage and the `datamemory` instance. It shares the memory with an external requester: a program/data loader, debug probe or DMA engine using a valid/ready handshake. The core has priority. A starvation counter bounds how long the external port waits, and a lock mode lets the external port own memory for bulk transfers. Whenever the core's access is not granted, the block raises `core_stall`, which freezes the pipeline.

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_starve_counter.sv | 34 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state and request bundle.
package Pipe_Buf_Reg_PKG;

  localparam int DMEM_AW        = 9;
  localparam int DMEM_DW        = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int WAIT_W         = 4;

  typedef enum logic [0:0] {ARB, LOCKED} arb_state_t;

  // One memory access: used for the core side, the ext side and the memory port.
  typedef struct packed {
    logic               rd;
    logic               wr;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic [2:0]         funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter: clear wins over increment, holds at MAX.
module starve_counter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int MAX = STARVE_MAX_DEF,
  parameter int W   = WAIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != W'(MAX)))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has priority, external port is
// protected from starvation and can lock the memory for bulk transfers.
// Request bundles are sized by the package widths, so DM_ADDRESS/DATA_W
// are expected to match DMEM_AW/DMEM_DW.
module dmem_arbiter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DM_ADDRESS = DMEM_AW,
  parameter int DATA_W     = DMEM_DW,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_valid,
  input  logic                  ext_we,
  input  logic                  ext_lock,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_funct3,
  output logic                  ext_ready,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t          state_q, state_d;
  logic                core_req, core_gnt, ext_gnt, starved;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  dmem_req_t           core_bus, ext_bus, mem_bus;

  assign core_req = core_rd | core_wr;
  assign starved  = (wait_cnt == WAIT_W'(STARVE_MAX));

  // Pack both requesters into the common bundle.
  always_comb begin
    core_bus        = '0;
    core_bus.rd     = core_rd;
    core_bus.wr     = core_wr;
    core_bus.addr   = core_addr;
    core_bus.wdata  = core_wdata;
    core_bus.funct3 = core_funct3;
    ext_bus         = '0;
    ext_bus.rd      = ~ext_we;
    ext_bus.wr      = ext_we;
    ext_bus.addr    = ext_addr;
    ext_bus.wdata   = ext_wdata;
    ext_bus.funct3  = ext_funct3;
  end

  // Arbitration FSM: grants and next state; no grant at all while in reset.
  always_comb begin
    state_d  = state_q;
    ext_gnt  = 1'b0;
    core_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB: begin
          ext_gnt  = ext_valid & (~core_req | starved);
          core_gnt = core_req & ~ext_gnt;
          if (ext_gnt && ext_lock) state_d = LOCKED;
        end
        LOCKED: begin
          // Ext keeps ownership through the cycle lock drops.
          ext_gnt = ext_valid;
          if (!ext_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  starve_counter #(.MAX(STARVE_MAX), .W(WAIT_W)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr_i (ext_gnt | (state_q == LOCKED)),
    .inc_i (ext_valid & ~ext_gnt),
    .cnt_o (wait_cnt)
  );

  // Memory port follows the winner; idle bus is all zeros.
  always_comb begin
    mem_bus = '0;
    if (ext_gnt)       mem_bus = ext_bus;
    else if (core_gnt) mem_bus = core_bus;
  end

  assign mem_rd     = mem_bus.rd;
  assign mem_wr     = mem_bus.wr;
  assign mem_addr   = mem_bus.addr;
  assign mem_wdata  = mem_bus.wdata;
  assign mem_funct3 = mem_bus.funct3;

  assign ext_ready  = ext_gnt;
  assign core_stall = core_req & ~core_gnt & ~reset;
  assign core_rdata = mem_rdata;

  // Ext read response: capture memory data one cycle after an ext read.
  always_comb begin
    rvalid_d = ext_gnt & ~ext_we;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
  end

  // Response registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector-table bench for dmem_arbiter with a memory model and a read scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_rd, core_wr, ext_valid, ext_we, ext_lock;
  logic [8:0]  core_addr, ext_addr, mem_addr;
  logic [31:0] core_wdata, ext_wdata, core_rdata, ext_rdata, mem_wdata, mem_rdata;
  logic [2:0]  core_funct3, ext_funct3, mem_funct3;
  logic        core_stall, ext_ready, ext_rvalid, mem_rd, mem_wr;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] exp_q [$];
  logic [31:0] last_rdata;

  localparam logic [2:0] CF3 = 3'b010;
  localparam logic [2:0] EF3 = 3'b001;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_lock(ext_lock),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_funct3(ext_funct3),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  // Combinational-read, clocked-write memory behind the arbiter.
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    string       name;
    logic        crd, cwr;
    logic [8:0]  caddr;
    logic [31:0] cwd;
    logic        ev, ewe, elk;
    logic [8:0]  eaddr;
    logic [31:0] ewd;
    logic        x_rdy, x_stall, x_mrd, x_mwr;
  } vec_t;

  function automatic vec_t mk(string n, logic crd, logic cwr, logic [8:0] caddr,
                              logic [31:0] cwd, logic ev, logic ewe, logic elk,
                              logic [8:0] eaddr, logic [31:0] ewd,
                              logic xr, logic xs, logic xmr, logic xmw);
    vec_t v;
    v.name = n; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
    v.ev = ev; v.ewe = ewe; v.elk = elk; v.eaddr = eaddr; v.ewd = ewd;
    v.x_rdy = xr; v.x_stall = xs; v.x_mrd = xmr; v.x_mwr = xmw;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one vector for one cycle, check outputs, then check the response.
  task automatic step(input vec_t v);
    logic [8:0]  ea;
    logic [31:0] ew, d;
    logic [2:0]  ef;
    core_rd = v.crd; core_wr = v.cwr; core_addr = v.caddr; core_wdata = v.cwd;
    ext_valid = v.ev; ext_we = v.ewe; ext_lock = v.elk;
    ext_addr = v.eaddr; ext_wdata = v.ewd;
    #3;
    if (v.x_rdy)                  begin ea = v.eaddr; ew = v.ewd; ef = EF3; end
    else if (v.x_mrd || v.x_mwr)  begin ea = v.caddr; ew = v.cwd; ef = CF3; end
    else                          begin ea = '0;      ew = '0;    ef = '0;  end
    chk({v.name, ".ext_ready"},  ext_ready,  v.x_rdy);
    chk({v.name, ".core_stall"}, core_stall, v.x_stall);
    chk({v.name, ".mem_rd"},     mem_rd,     v.x_mrd);
    chk({v.name, ".mem_wr"},     mem_wr,     v.x_mwr);
    chk({v.name, ".mem_addr"},   mem_addr,   ea);
    chk({v.name, ".mem_funct3"}, mem_funct3, ef);
    if (v.x_mwr) chk({v.name, ".mem_wdata"}, mem_wdata, ew);
    if (v.x_mrd && !v.x_rdy) chk({v.name, ".core_rdata"}, core_rdata, ref_mem[v.caddr]);
    if (v.x_rdy && !v.ewe) exp_q.push_back(ref_mem[v.eaddr]);
    if (v.x_mwr) ref_mem[ea] = ew;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk({v.name, ".ext_rvalid"}, ext_rvalid, 1'b1);
      chk({v.name, ".ext_rdata"},  ext_rdata,  d);
      last_rdata = d;
    end else begin
      chk({v.name, ".ext_rvalid"},    ext_rvalid, 1'b0);
      chk({v.name, ".ext_rdata_hold"}, ext_rdata, last_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [$];
    last_rdata = '0;
    core_funct3 = CF3; ext_funct3 = EF3;
    // Reset with both requesters active: nothing may be granted.
    reset = 1'b1;
    core_rd = 1'b0; core_wr = 1'b1; core_addr = 9'h010; core_wdata = 32'h1;
    ext_valid = 1'b1; ext_we = 1'b0; ext_lock = 1'b1; ext_addr = 9'h020; ext_wdata = '0;
    @(posedge clk); #1; #3;
    chk("rst.ext_ready", ext_ready, 1'b0);
    chk("rst.core_stall", core_stall, 1'b0);
    chk("rst.mem_rd", mem_rd, 1'b0);
    chk("rst.mem_wr", mem_wr, 1'b0);
    @(posedge clk); #1;
    chk("rst.ext_rvalid", ext_rvalid, 1'b0);
    chk("rst.ext_rdata", ext_rdata, 32'h0);
    reset = 1'b0;

    //             name   crd cwr caddr  cwd           ev ewe lk eaddr  ewd           rdy stl mrd mwr
    tbl.push_back(mk("sw",    0, 1, 9'h010, 32'hDEADBEEF, 0, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1));
    tbl.push_back(mk("erd",   0, 0, 9'h000, 32'h0,        1, 0, 0, 9'h010, 32'h0,        1, 0, 1, 0));
    tbl.push_back(mk("cprio", 0, 1, 9'h020, 32'h12345678, 1, 1, 0, 9'h030, 32'hA5A5A5A5, 0, 0, 0, 1));
    tbl.push_back(mk("ewr",   0, 0, 9'h000, 32'h0,        1, 1, 0, 9'h030, 32'hA5A5A5A5, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("starve%0d", i), 1, 0, 9'h010, 32'h0, 1, 1, 0, 9'h040, 32'h0BADF00D, 0, 0, 1, 0));
    tbl.push_back(mk("starve_gnt", 1, 0, 9'h010, 32'h0,   1, 1, 0, 9'h040, 32'h0BADF00D, 1, 1, 0, 1));
    tbl.push_back(mk("crd_ewr", 1, 0, 9'h040, 32'h0,      0, 0, 0, 9'h000, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("wclr",  1, 0, 9'h040, 32'h0,        1, 0, 0, 9'h010, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk("erd2",  0, 0, 9'h000, 32'h0,        1, 0, 0, 9'h010, 32'h0,        1, 0, 1, 0));
    tbl.push_back(mk("b2b_a", 0, 0, 9'h000, 32'h0,        1, 0, 0, 9'h020, 32'h0,        1, 0, 1, 0));
    tbl.push_back(mk("b2b_b", 0, 0, 9'h000, 32'h0,        1, 0, 0, 9'h030, 32'h0,        1, 0, 1, 0));
    tbl.push_back(mk("idle",  0, 0, 9'h000, 32'h0,        0, 0, 0, 9'h000, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk("lk0",   0, 0, 9'h000, 32'h0,        1, 1, 1, 9'h100, 32'h11,       1, 0, 0, 1));
    tbl.push_back(mk("lk1",   1, 0, 9'h100, 32'h0,        1, 1, 1, 9'h101, 32'h22,       1, 1, 0, 1));
    tbl.push_back(mk("lk2",   1, 0, 9'h100, 32'h0,        1, 1, 1, 9'h102, 32'h33,       1, 1, 0, 1));
    tbl.push_back(mk("lkgap", 1, 0, 9'h100, 32'h0,        0, 0, 1, 9'h000, 32'h0,        0, 1, 0, 0));
    tbl.push_back(mk("lkexit",1, 0, 9'h100, 32'h0,        1, 0, 0, 9'h101, 32'h0,        1, 1, 1, 0));
    tbl.push_back(mk("lkpost",1, 0, 9'h102, 32'h0,        0, 0, 0, 9'h000, 32'h0,        0, 0, 1, 0));
    foreach (tbl[i]) step(tbl[i]);

    // Reset while LOCKED with a read response outstanding.
    step(mk("lkrd", 0, 0, 9'h000, 32'h0, 1, 0, 1, 9'h100, 32'h0, 1, 0, 1, 0));
    reset = 1'b1;
    core_rd = 1'b1; core_wr = 1'b0; core_addr = 9'h100;
    ext_valid = 1'b1; ext_we = 1'b0; ext_lock = 1'b1; ext_addr = 9'h101;
    #3;
    chk("rstlk.ext_ready", ext_ready, 1'b0);
    chk("rstlk.core_stall", core_stall, 1'b0);
    chk("rstlk.mem_rd", mem_rd, 1'b0);
    chk("rstlk.mem_wr", mem_wr, 1'b0);
    @(posedge clk); #1;
    chk("rstlk.ext_rvalid", ext_rvalid, 1'b0);
    chk("rstlk.ext_rdata", ext_rdata, 32'h0);
    last_rdata = '0;
    exp_q.delete();
    reset = 1'b0;
    // Back in ARB with a fresh counter: core wins over a pending ext request.
    step(mk("rstlk.arb", 1, 0, 9'h100, 32'h0, 1, 0, 1, 9'h101, 32'h0, 0, 0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
